// File: rtl/fifo_byte_stream.sv
// Byte-granular width-converting FIFO: variable-count wide pushes, power-of-two narrow pops.
// Circular byte store with independent push/pop acceptance judged on the pre-cycle count.
module fifo_byte_stream #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned WR_BYTES     = 8,
    parameter int unsigned RD_BYTES_MAX = 4,
    parameter int unsigned AFULL_THRESH = 56
) (
    input  logic                                        clock,
    input  logic                                        reset_n,
    input  logic                                        fifo_write,
    input  logic [$clog2(WR_BYTES+1)-1:0]               wr_count,
    input  logic [WR_BYTES*8-1:0]                       fifo_data_in,
    input  logic                                        fifo_read,
    input  logic [$clog2($clog2(RD_BYTES_MAX)+1)-1:0]   size,
    input  logic                                        err_clr,
    output logic [RD_BYTES_MAX*8-1:0]                   fifo_data_out,
    output logic                                        fifo_valid_out,
    output logic                                        fifo_empty,
    output logic                                        fifo_full,
    output logic                                        fifo_almost_full,
    output logic [ADDR_WIDTH:0]                         data_remain,
    output logic                                        fifo_overflow,
    output logic                                        fifo_underflow,
    output logic [1:0]                                  err_sticky
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned SZ_MAX = $clog2(RD_BYTES_MAX);
    localparam int unsigned RD_W   = RD_BYTES_MAX * 8;

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [RD_W-1:0]       rdata_q, rdata_d;
    logic                  valid_q;
    logic                  of_q, uf_q;
    logic                  empty_q, full_q, afull_q;
    logic [1:0]            err_q, err_d;

    logic [CNT_W-1:0]      wr_len, rd_len, space;
    logic                  size_ok, wr_acc, rd_acc, of_d, uf_d;
    logic                  empty_d, full_d, afull_d;
    logic [WR_BYTES-1:0]   wr_be;

    // Acceptance, pointer/count update, flag decode and pop data gather.
    always_comb begin
        wr_len  = CNT_W'(wr_count);
        space   = CNT_W'(DEPTH) - count_q;
        size_ok = (32'(size) <= SZ_MAX);
        rd_len  = '0;
        if (size_ok) begin
            rd_len = CNT_W'(1) << size;
        end

        wr_acc = fifo_write && (wr_len != '0) && (wr_len <= space);
        of_d   = fifo_write && (wr_len != '0) && !wr_acc;
        rd_acc = fifo_read && size_ok && (rd_len <= count_q);
        uf_d   = fifo_read && !rd_acc;

        for (int i = 0; i < WR_BYTES; i++) begin
            wr_be[i] = wr_acc && (CNT_W'(i) < wr_len);
        end

        waddr_d = wr_acc ? waddr_q + ADDR_WIDTH'(wr_count) : waddr_q;
        raddr_d = rd_acc ? raddr_q + ADDR_WIDTH'(rd_len) : raddr_q;
        count_d = count_q + (wr_acc ? wr_len : '0) - (rd_acc ? rd_len : '0);

        empty_d = (count_d == '0);
        full_d  = (count_d > CNT_W'(DEPTH - WR_BYTES));
        afull_d = (count_d >= CNT_W'(AFULL_THRESH));

        // Set wins over clear.
        err_d = err_clr ? 2'b00 : err_q;
        err_d = err_d | {uf_d, of_d};

        rdata_d = rdata_q;
        if (rd_acc) begin
            rdata_d = '0;
            for (int j = 0; j < RD_BYTES_MAX; j++) begin
                if (CNT_W'(j) < rd_len) begin
                    rdata_d[j*8 +: 8] = mem_q[raddr_q + ADDR_WIDTH'(j)];
                end
            end
        end
    end

    // Byte store; contents are don't-care after reset so it carries none.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WR_BYTES; i++) begin
            if (wr_be[i]) begin
                mem_q[waddr_q + ADDR_WIDTH'(i)] <= fifo_data_in[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waddr_q <= '0;
            raddr_q <= '0;
            count_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            valid_q <= rd_acc;
            of_q    <= of_d;
            uf_q    <= uf_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            err_q   <= err_d;
        end
    end

    assign fifo_data_out    = rdata_q;
    assign fifo_valid_out   = valid_q;
    assign fifo_empty       = empty_q;
    assign fifo_full        = full_q;
    assign fifo_almost_full = afull_q;
    assign data_remain      = count_q;
    assign fifo_overflow    = of_q;
    assign fifo_underflow   = uf_q;
    assign err_sticky       = err_q;

endmodule

// File: tb/tb_fifo_byte_stream.sv
// Bench for fifo_byte_stream: byte-queue reference model plus a scoreboard of expected pop words.
module tb_fifo_byte_stream;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fifo_write;
    logic [3:0]  wr_count;
    logic [63:0] fifo_data_in;
    logic        fifo_read;
    logic [1:0]  size;
    logic        err_clr;
    logic [31:0] fifo_data_out;
    logic        fifo_valid_out;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic [6:0]  data_remain;
    logic        fifo_overflow;
    logic        fifo_underflow;
    logic [1:0]  err_sticky;

    fifo_byte_stream dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .fifo_write       (fifo_write),
        .wr_count         (wr_count),
        .fifo_data_in     (fifo_data_in),
        .fifo_read        (fifo_read),
        .size             (size),
        .err_clr          (err_clr),
        .fifo_data_out    (fifo_data_out),
        .fifo_valid_out   (fifo_valid_out),
        .fifo_empty       (fifo_empty),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .data_remain      (data_remain),
        .fifo_overflow    (fifo_overflow),
        .fifo_underflow   (fifo_underflow),
        .err_sticky       (err_sticky)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  mq[$];
    logic [31:0] exp_q[$];
    logic [1:0]  msticky;
    logic [31:0] mdout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, check every output after the edge.
    task automatic cycle(input logic wr, input int wc, input logic [63:0] d,
                         input logic rd, input int sz, input logic clr);
        int          cnt;
        bit          wacc, racc, eof, euf;
        logic [31:0] w;
        cnt  = mq.size();
        wacc = wr && (wc != 0) && (wc <= 64 - cnt);
        eof  = wr && (wc != 0) && !wacc;
        racc = rd && (sz <= 2) && ((1 << sz) <= cnt);
        euf  = rd && !racc;

        fifo_write   = wr;
        wr_count     = 4'(wc);
        fifo_data_in = d;
        fifo_read    = rd;
        size         = 2'(sz);
        err_clr      = clr;

        if (racc) begin
            w = '0;
            for (int j = 0; j < (1 << sz); j++) w[j*8 +: 8] = mq.pop_front();
            exp_q.push_back(w);
            mdout = w;
        end
        if (wacc) begin
            for (int i = 0; i < wc; i++) mq.push_back(d[i*8 +: 8]);
        end
        msticky = clr ? 2'b00 : msticky;
        msticky = msticky | {euf, eof};

        @(posedge clock);
        #1;
        chk("valid_out", fifo_valid_out, racc);
        if (fifo_valid_out) begin
            if (exp_q.size() == 0) chk("sb_underrun", exp_q.size(), 1);
            else                   chk("data_out", fifo_data_out, exp_q.pop_front());
        end else begin
            chk("data_hold", fifo_data_out, mdout);
        end
        chk("data_remain", data_remain, mq.size());
        chk("empty", fifo_empty, mq.size() == 0);
        chk("full", fifo_full, mq.size() > 56);
        chk("almost_full", fifo_almost_full, mq.size() >= 56);
        chk("overflow", fifo_overflow, eof);
        chk("underflow", fifo_underflow, euf);
        chk("err_sticky", err_sticky, msticky);

        fifo_write = 1'b0;
        wr_count   = '0;
        fifo_read  = 1'b0;
        size       = '0;
        err_clr    = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        reset_n      = 1'b0;
        fifo_write   = 1'b0;
        wr_count     = '0;
        fifo_data_in = '0;
        fifo_read    = 1'b0;
        size         = '0;
        err_clr      = 1'b0;
        msticky      = 2'b00;
        mdout        = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_empty", fifo_empty, 1);
        chk("rst_remain", data_remain, 0);
        chk("rst_valid", fifo_valid_out, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_dout", fifo_data_out, 0);
        reset_n = 1'b1;

        // Basic push and narrow pops.
        cycle(1, 8, 64'h0706050403020100, 0, 0, 0);
        cycle(0, 0, 64'h0, 1, 2, 0);
        cycle(0, 0, 64'h0, 1, 0, 0);
        chk("remain_3", data_remain, 3);

        // Reach 20 bytes with a pop in flight, then reset between edges.
        cycle(1, 8, 64'h1716151413121110, 0, 0, 0);
        cycle(1, 8, 64'h1F1E1D1C1B1A1918, 0, 0, 0);
        cycle(1, 2, 64'h000000000000BEEF, 1, 0, 0);
        chk("pre_rst_remain", data_remain, 20);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_full", fifo_full, 0);
        chk("mid_rst_valid", fifo_valid_out, 0);
        chk("mid_rst_remain", data_remain, 0);
        mq.delete();
        exp_q.delete();
        msticky = 2'b00;
        mdout   = '0;
        #1;
        reset_n = 1'b1;

        // Fill to threshold, then to full, overflow, top up to 64.
        for (int k = 0; k < 7; k++) cycle(1, 8, rnd64(), 0, 0, 0);
        chk("afull_56", fifo_almost_full, 1);
        cycle(1, 4, rnd64(), 0, 0, 0);
        cycle(1, 8, rnd64(), 0, 0, 0);
        chk("ovf_sticky", err_sticky, 2'b01);
        chk("ovf_remain", data_remain, 60);
        cycle(1, 4, rnd64(), 0, 0, 0);
        chk("remain_64", data_remain, 64);
        cycle(0, 0, 64'h0, 0, 0, 1);

        // Drain, underflow on empty, illegal size with data present.
        for (int k = 0; k < 16; k++) cycle(0, 0, 64'h0, 1, 2, 0);
        cycle(0, 0, 64'h0, 1, 0, 0);
        cycle(1, 8, rnd64(), 0, 0, 0);
        cycle(1, 8, rnd64(), 0, 0, 0);
        cycle(0, 0, 64'h0, 1, 3, 0);
        cycle(0, 0, 64'h0, 0, 0, 1);

        // Move both pointers to 60, then push across the wrap.
        for (int k = 0; k < 4; k++) cycle(0, 0, 64'h0, 1, 2, 0);
        for (int k = 0; k < 5; k++) cycle(1, 8, rnd64(), 0, 0, 0);
        cycle(1, 4, rnd64(), 0, 0, 0);
        for (int k = 0; k < 11; k++) cycle(0, 0, 64'h0, 1, 2, 0);
        cycle(1, 8, 64'hA7A6A5A4A3A2A1A0, 0, 0, 0);
        cycle(0, 0, 64'h0, 1, 2, 0);
        chk("wrap_lo", fifo_data_out, 32'hA3A2A1A0);
        cycle(0, 0, 64'h0, 1, 2, 0);
        chk("wrap_hi", fifo_data_out, 32'hA7A6A5A4);

        // Same-cycle push+pop at 60: push rejected on the pre-cycle count.
        for (int k = 0; k < 7; k++) cycle(1, 8, rnd64(), 0, 0, 0);
        cycle(1, 4, rnd64(), 0, 0, 0);
        cycle(1, 8, rnd64(), 1, 2, 0);
        chk("same_cyc_remain", data_remain, 56);
        cycle(0, 0, 64'h0, 0, 0, 1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 8), rnd64(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        chk("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
